// File: rtl/dbpsk_pkg.sv
// Shared types and constants for the DBPSK frame encoder: FSM states,
// bipolar symbol codes and default framing parameters.
package dbpsk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SYNC,
      ST_PAYLOAD,
      ST_GAP
   } state_t;

   localparam logic signed [1:0] SYM_POS  = 2'sb01;
   localparam logic signed [1:0] SYM_NEG  = 2'sb11;
   localparam logic signed [1:0] SYM_ZERO = 2'sb00;

   localparam int         DEF_PRE_LEN   = 16;
   localparam int         DEF_SYNC_W    = 8;
   localparam logic [7:0] DEF_SYNC_WORD = 8'b1101_0011;

   // Encoded 0 maps to +1, encoded 1 maps to -1.
   function automatic logic signed [1:0] map_sym(input logic bit_in);
      return bit_in ? SYM_NEG : SYM_POS;
   endfunction

endpackage

// File: rtl/dbpsk_diff_mapper.sv
// Differential (XOR) encoder plus bipolar symbol mapper; one register stage
// between the raw framed bit and the modulator-facing outputs.
module dbpsk_diff_mapper
   import dbpsk_pkg::*;
(
   input  logic              clk_o,
   input  logic              reset_n,
   input  logic              i_clear,
   input  logic              i_valid,
   input  logic              i_raw,
   output logic              o_tx_bit,
   output logic signed [1:0] o_tx_sym,
   output logic              o_tx_valid
);

   logic              r_d;
   logic signed [1:0] r_sym;
   logic              r_valid;
   logic              w_d_prev;
   logic              w_d_next;

   // Clear forces d_prev to 0; with i_valid it also encodes the first bit of a frame.
   assign w_d_prev = i_clear ? 1'b0 : r_d;
   assign w_d_next = w_d_prev ^ i_raw;

   always_ff @(posedge clk_o or negedge reset_n) begin
      if (!reset_n) begin
         r_d     <= 1'b0;
         r_sym   <= SYM_ZERO;
         r_valid <= 1'b0;
      end else if (i_valid) begin
         r_d     <= w_d_next;
         r_sym   <= map_sym(w_d_next);
         r_valid <= 1'b1;
      end else begin
         r_d     <= w_d_prev;
         r_sym   <= SYM_ZERO;
         r_valid <= 1'b0;
      end
   end

   assign o_tx_bit   = r_d;
   assign o_tx_sym   = r_sym;
   assign o_tx_valid = r_valid;

endmodule

// File: rtl/dbpsk_frame_encoder.sv
// Frames the free-running PN stream (preamble, sync word, payload, gap) and
// hands each framed bit to the differential mapper.
//
// state       | meaning
// ST_IDLE     | waiting for tx_en (without abort)
// ST_PREAMBLE | PRE_LEN bits of 1,0,1,0,...
// ST_SYNC     | SYNC_WORD, MSB first
// ST_PAYLOAD  | PAY_LEN bits taken from data_PN
// ST_GAP      | GAP_LEN idle cycles, then next frame or IDLE
module dbpsk_frame_encoder
   import dbpsk_pkg::*;
#(
   parameter int                PRE_LEN   = DEF_PRE_LEN,
   parameter int                SYNC_W    = DEF_SYNC_W,
   parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
   parameter int                PAY_LEN   = 127,
   parameter int                GAP_LEN   = 4,
   parameter int                CNT_W     = 8
) (
   input  logic              clk_o,
   input  logic              reset_n,
   input  logic              i_tx_en,
   input  logic              i_abort,
   input  logic              i_data_PN,
   output logic              o_tx_bit,
   output logic signed [1:0] o_tx_sym,
   output logic              o_tx_valid,
   output logic              o_frame_start,
   output logic              o_frame_done,
   output logic              o_busy
);

   localparam int SW_IW = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
   localparam logic [CNT_W-1:0] SYN_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_frame_start;
   logic               r_frame_done;
   logic               w_raw;
   logic               w_valid;
   logic               w_clear;
   logic               w_first;
   logic               w_last;
   logic [SW_IW-1:0]   w_sync_idx;

   assign w_sync_idx = SW_IW'(SYNC_W - 1) - r_cnt[SW_IW-1:0];

   always_ff @(posedge clk_o or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_frame_start <= w_valid & w_first;
         r_frame_done  <= w_last;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_raw       = 1'b0;
      w_valid     = 1'b0;
      w_clear     = 1'b0;
      w_first     = 1'b0;
      w_last      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (i_tx_en && !i_abort) begin
               w_state_nxt = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            w_raw   = ~r_cnt[0];
            w_valid = 1'b1;
            w_first = (r_cnt == '0);
            w_clear = w_first;
            if (r_cnt == PRE_LAST) begin
               w_state_nxt = ST_SYNC;
               w_cnt_nxt   = '0;
            end
         end
         ST_SYNC: begin
            w_raw   = SYNC_WORD[w_sync_idx];
            w_valid = 1'b1;
            if (r_cnt == SYN_LAST) begin
               w_state_nxt = ST_PAYLOAD;
               w_cnt_nxt   = '0;
            end
         end
         ST_PAYLOAD: begin
            w_raw   = i_data_PN;
            w_valid = 1'b1;
            if (r_cnt == PAY_LAST) begin
               w_last      = 1'b1;
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
            end
         end
         ST_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = i_tx_en ? ST_PREAMBLE : ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Abort drops the frame on the spot: no symbol, no done pulse, fresh d_prev.
      if (i_abort && r_state != ST_IDLE) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_valid     = 1'b0;
         w_first     = 1'b0;
         w_last      = 1'b0;
         w_clear     = 1'b1;
      end
   end

   dbpsk_diff_mapper u_mapper (
      .clk_o      (clk_o),
      .reset_n    (reset_n),
      .i_clear    (w_clear),
      .i_valid    (w_valid),
      .i_raw      (w_raw),
      .o_tx_bit   (o_tx_bit),
      .o_tx_sym   (o_tx_sym),
      .o_tx_valid (o_tx_valid)
   );

   assign o_frame_start = r_frame_start;
   assign o_frame_done  = r_frame_done;
   assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: doc/dbpsk_frame_encoder.md
Name: dbpsk_frame_encoder

Overview:
- Consumes the 1-bit/clk PN payload stream (data_PN) from the m-sequence generator.
- Wraps it into frames: preamble, sync word, PAY_LEN payload bits, then an idle gap.
- Differentially encodes every framed bit for DBPSK and maps it to a signed bipolar symbol for the downstream carrier modulator.
- One bit per clk_o cycle; no oversampling.

Parameters:
- PRE_LEN, 16, preamble length in bits; raw pattern alternates 1,0,1,0,… starting with 1.
- SYNC_W, 8, sync word width.
- SYNC_WORD, 8'b1101_0011, sync word, sent MSB first.
- PAY_LEN, 127, payload bits per frame (1..255).
- GAP_LEN, 4, idle cycles between frames (1..255).
- CNT_W, 8, bit counter width; must hold max(PRE_LEN, SYNC_W, PAY_LEN, GAP_LEN)-1.

Ports:
- clk_o, in, 1, system/bit clock, shared with the PN generator.
- reset_n, in, 1, asynchronous active-low reset.
- tx_en, in, 1, level: start or continue framing.
- abort, in, 1, synchronous frame abort; has priority over tx_en.
- data_PN, in, 1, PN payload bit; sampled only in PAYLOAD.
- tx_bit, out, 1, differentially encoded bit.
- tx_sym, out, 2 (signed), bipolar symbol: encoded 0 -> +1 (2'b01), encoded 1 -> -1 (2'b11), idle -> 0 (2'b00).
- tx_valid, out, 1, tx_bit and tx_sym are valid this cycle.
- frame_start, out, 1, one-cycle pulse with the first preamble symbol.
- frame_done, out, 1, one-cycle pulse with the last payload symbol.
- busy, out, 1, state is not IDLE.

Behaviour:
- Reset is applied only through reset_n (asynchronous, active-low) on clk_o.
- Reset values:
  - state IDLE, counter 0, differential state 0.
  - tx_bit 0, tx_sym 2'b00, tx_valid 0, frame_start 0, frame_done 0, busy 0.
- FSM states: IDLE, PREAMBLE, SYNC, PAYLOAD, GAP.
  - IDLE: if tx_en and !abort, go to PREAMBLE, clear counter, clear differential state to 0.
  - PREAMBLE: after PRE_LEN cycles, go to SYNC.
  - SYNC: after SYNC_W cycles, go to SYNC_W-1..0 bit order, i.e. MSB first; then go to PAYLOAD.
  - PAYLOAD: after PAY_LEN cycles, go to GAP.
  - GAP: after GAP_LEN cycles, go to PREAMBLE (counter and differential state cleared) if tx_en, else IDLE.
  - The counter counts 0..LEN-1 in each state and clears on every state change.
- tx_en deasserted mid-frame has no effect; the frame always completes.
- abort high in any state other than IDLE:
  - Next state is IDLE.
  - Outputs return to idle values at the next edge.
  - frame_done is not pulsed.
  - The differential state is cleared.
- Raw bit per state:
  - PREAMBLE: ~counter[0].
  - SYNC: SYNC_WORD[SYNC_W-1-counter].
  - PAYLOAD: data_PN.
- Differential encoding: d = d_prev XOR raw, with d_prev = 0 at the start of each frame. The registered d drives tx_bit.
- Latency: a raw bit selected in cycle n appears on tx_bit/tx_sym/tx_valid at edge n+1 (one register stage).
- tx_valid is high for exactly PRE_LEN+SYNC_W+PAY_LEN consecutive cycles per frame.
- In IDLE and GAP: tx_valid 0, tx_sym 2'b00, tx_bit holds its last value.
- frame_start is coincident with the first valid preamble symbol; frame_done is coincident with the last payload symbol.
- Back-to-back frames with tx_en held: exactly GAP_LEN invalid cycles between frame_done and the next frame_start.
- abort and tx_en both high in IDLE: stay in IDLE.
- The PN generator free-runs. The payload is whatever data_PN carries during PAYLOAD; no handshake back to it.

Decomposition:
- Shared package dbpsk_pkg holds:
  - state enum.
  - symbol constants SYM_POS=2'sb01, SYM_NEG=2'sb11, SYM_ZERO=2'sb00.
  - default PRE_LEN/SYNC_WORD.
- One sub-module dbpsk_diff_mapper:
  - Inputs: clk_o, reset_n, clear, valid_in, raw bit.
  - Outputs: registered tx_bit, tx_sym, tx_valid.
  - Contains the XOR state and the bipolar mapping.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: assert reset_n=0 mid-PAYLOAD -> all outputs go to reset values immediately (asynchronously); busy=0; after release, IDLE until tx_en.
- Single frame: tx_en high one cycle at edge k -> frame_start and tx_valid rise at edge k+2; tx_valid high 151 cycles; frame_done on the 151st; then 4 invalid cycles and IDLE.
- Encoding check:
  - Preamble tx_bit sequence is 1,1,0,0 repeated ×4.
  - Sync encodes to 1,0,0,1,1,1,0,1.
  - tx_sym equals -1,+1 per bit accordingly.
  - Payload must match a bit-exact model of x^8 LFSR taps [2,3,4,7] seeded 0x01, XOR-differentially encoded.
- Continuous mode: tx_en held for 3 frames -> 3 frame_start pulses spaced 155 cycles apart; differential state restarts at 0 each frame (first preamble bit always 1).
- Abort: abort at payload bit 50 -> tx_valid 0 at the next edge; no frame_done; IDLE. With tx_en still high, the next frame starts one cycle later with a fresh preamble.
- tx_en dropped during SYNC -> the frame completes normally, frame_done pulses, return to IDLE after the gap.
